// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM with clear-on-reset.
package sdp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Same-address read-during-write behaviour
    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Widest word the parity helper covers; callers zero-extend into it
    localparam int PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total number of ones even
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Bare memory array with one write port, one asynchronous-address read port
// and the same-address read-during-write bypass. No reset: contents are only
// ever changed through the write port.
module sdp_ram_core
    import sdp_ram_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data, forwarding the incoming word on a same-address collision in write-first mode
    always_comb begin
        rdata = mem[raddr];
        if (READ_MODE == WRITE_FIRST && we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/sdp_ram_init.sv
// Simple dual-port RAM that zeroes every location after reset before
// accepting traffic. Read latency is 1 cycle, or 2 with OUT_REG=1.
// Optional feature: define SDP_RAM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on parity_err, aligned with dout_valid.
module sdp_ram_init
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int READ_MODE = READ_FIRST,
    parameter int OUT_REG   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              init_busy
`ifdef SDP_RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SDP_RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_ptr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_wword;
    logic [WORD_W-1:0] mem_rword;
    logic              rd_en_p0;

    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
`ifdef SDP_RAM_PARITY_EN
    logic              perr_p1;
`endif

    // State register: reset always restarts the clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR on the cycle the last address is zeroed
    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && (&clr_ptr)) begin
            state_d = READY;
        end
    end

    // Clear pointer walks every address once per sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (state_q == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Write-port arbitration and read qualification; nothing reaches memory in a reset cycle
    always_comb begin
        init_busy = (state_q == CLEAR);
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        rd_en_p0  = 1'b0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
            end else begin
                mem_we    = we;
                mem_waddr = waddr;
                mem_wdata = wdata;
                rd_en_p0  = re;
            end
        end
    end

`ifdef SDP_RAM_PARITY_EN
    assign mem_wword = {even_parity(PAR_MAX_W'(mem_wdata)), mem_wdata};
`else
    assign mem_wword = mem_wdata;
`endif

    sdp_ram_core #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .READ_MODE (READ_MODE)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wword),
        .raddr (raddr),
        .rdata (mem_rword)
    );

    // ---- stage p0 -> p1: registered read data, held while no read is issued ----
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
            perr_p1 <= 1'b0;
`endif
        end else begin
            vld_p1 <= rd_en_p0;
            if (rd_en_p0) begin
                dout_p1 <= mem_rword[DATA_W-1:0];
            end
`ifdef SDP_RAM_PARITY_EN
            perr_p1 <= rd_en_p0 & (^mem_rword);
`endif
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] dout_p2;
            logic              vld_p2;
`ifdef SDP_RAM_PARITY_EN
            logic              perr_p2;
`endif

            // ---- stage p1 -> p2: optional output register, same hold behaviour ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_p2 <= '0;
                    vld_p2  <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
                    perr_p2 <= 1'b0;
`endif
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        dout_p2 <= dout_p1;
                    end
`ifdef SDP_RAM_PARITY_EN
                    perr_p2 <= perr_p1;
`endif
                end
            end

            assign dout       = dout_p2;
            assign dout_valid = vld_p2;
`ifdef SDP_RAM_PARITY_EN
            assign parity_err = perr_p2;
`endif
        end else begin : g_noreg
            assign dout       = dout_p1;
            assign dout_valid = vld_p1;
`ifdef SDP_RAM_PARITY_EN
            assign parity_err = perr_p1;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_init.sv
// Bench for sdp_ram_init: a default instance (8x64, read-first, latency 1)
// and a 16x16 write-first instance with the output register (latency 2),
// both checked every cycle against an array-based model.
module tb_sdp_ram_init;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [5:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [5:0]  raddr;

    logic [7:0]  dout0;
    logic        vld0;
    logic        busy0;
    logic [15:0] dout1;
    logic        vld1;
    logic        busy1;
`ifdef SDP_RAM_PARITY_EN
    logic        perr0;
    logic        perr1;
    bit          corrupt = 1'b0;
`endif

    always #5 clk = ~clk;

    sdp_ram_init #(.DATA_W(8), .ADDR_W(6), .READ_MODE(0), .OUT_REG(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata[7:0]),
        .re         (re),
        .raddr      (raddr),
        .dout       (dout0),
        .dout_valid (vld0),
        .init_busy  (busy0)
`ifdef SDP_RAM_PARITY_EN
        ,
        .parity_err (perr0)
`endif
    );

    sdp_ram_init #(.DATA_W(16), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr[3:0]),
        .wdata      (wdata),
        .re         (re),
        .raddr      (raddr[3:0]),
        .dout       (dout1),
        .dout_valid (vld1),
        .init_busy  (busy1)
`ifdef SDP_RAM_PARITY_EN
        ,
        .parity_err (perr1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit mon    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: plain arrays, a remaining-clear counter and a read-result delay slot
    logic [7:0]  m0 [64];
    logic [15:0] m1 [16];
    int          c0, c1;
    bit          b0, b1;
    logic [7:0]  e0_d, r0;
    bit          e0_v;
    logic [15:0] e1_d, e1_pd, nd1;
    bit          e1_v, e1_pv, nv1;

    always @(posedge clk) begin
        if (rst) begin
            b0 = 1; c0 = 0; e0_d = '0; e0_v = 0;
            b1 = 1; c1 = 0; e1_d = '0; e1_v = 0; e1_pv = 0; e1_pd = '0;
        end else begin
            // 8x64, old data on collision, result visible after this edge
            if (b0) begin
                m0[c0[5:0]] = '0;
                c0++;
                if (c0 == 64) b0 = 0;
                e0_v = 0;
            end else begin
                r0 = m0[raddr];
                if (we) m0[waddr] = wdata[7:0];
                e0_v = re;
                if (re) e0_d = r0;
            end
            // 16x16, new data on collision, result visible one edge later
            nv1 = 0; nd1 = '0;
            if (b1) begin
                m1[c1[3:0]] = '0;
                c1++;
                if (c1 == 16) b1 = 0;
            end else begin
                if (we) m1[waddr[3:0]] = wdata;
                if (re) begin nv1 = 1; nd1 = m1[raddr[3:0]]; end
            end
            e1_v = e1_pv;
            if (e1_pv) e1_d = e1_pd;
            e1_pv = nv1;
            e1_pd = nd1;
        end
    end

    // Compare process: every cycle after the first reset
    always @(negedge clk) begin
        if (mon) begin
            chk("busy0", 32'(busy0), 32'(b0));
            chk("vld0",  32'(vld0),  32'(e0_v));
            chk("dout0", 32'(dout0), 32'(e0_d));
            chk("busy1", 32'(busy1), 32'(b1));
            chk("vld1",  32'(vld1),  32'(e1_v));
            chk("dout1", 32'(dout1), 32'(e1_d));
`ifdef SDP_RAM_PARITY_EN
            if (!corrupt) chk("perr0", 32'(perr0), 32'h0);
            chk("perr1", 32'(perr1), 32'h0);
`endif
        end
    end

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        we = 1; waddr = a; wdata = d; re = 0;
        @(negedge clk);
        we = 0;
    endtask

    initial begin
        int n0, n1;
        rst = 1; we = 0; re = 0; waddr = '0; raddr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        mon = 1;
        chk("rst_dout0", 32'(dout0), 32'h0);
        chk("rst_vld0",  32'(vld0),  32'h0);
        chk("rst_busy0", 32'(busy0), 32'h1);
        chk("rst_busy1", 32'(busy1), 32'h1);

        // Clear sweep with user traffic held active throughout
        we = 1; waddr = 6'd5; wdata = 16'h00AA; re = 1; raddr = 6'd5;
        rst = 0;
        n0 = 0; n1 = 0;
        while (busy0 && n0 < 200) begin
            n0++;
            if (busy1) n1++;
            @(negedge clk);
        end
        chk("clear_cycles0", 32'(n0), 32'd64);
        chk("clear_cycles1", 32'(n1), 32'd16);
        we = 0;
        for (int i = 0; i < 64; i++) begin
            re = 1; raddr = 6'(i);
            @(negedge clk);
            chk("clear_rd_val0", 32'(dout0), 32'h0);
            chk("clear_rd_vld0", 32'(vld0), 32'h1);
        end
        re = 0;
        @(negedge clk);

        // Basic write then back-to-back reads
        wr(6'd0, 16'h0001);
        wr(6'd1, 16'h0002);
        wr(6'd2, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            re = 1; raddr = 6'(i);
            @(negedge clk);
            chk("basic_rd0", 32'(dout0), 32'(i + 1));
            chk("basic_vld0", 32'(vld0), 32'h1);
            if (i >= 1) chk("basic_rd1", 32'(dout1), 32'(i));
        end
        re = 0;
        @(negedge clk);
        chk("basic_hold0", 32'(dout0), 32'h03);
        chk("basic_idle0", 32'(vld0), 32'h0);
        chk("basic_rd1_last", 32'(dout1), 32'h0003);
        @(negedge clk);

        // Same-address collision
        wr(6'd3, 16'h0004);
        we = 1; waddr = 6'd3; wdata = 16'h0005; re = 1; raddr = 6'd3;
        @(negedge clk);
        we = 0; re = 0;
        chk("coll_readfirst0", 32'(dout0), 32'h04);
        chk("coll_vld1_early", 32'(vld1), 32'h0);
        @(negedge clk);
        chk("coll_writefirst1", 32'(dout1), 32'h0005);
        chk("coll_vld1", 32'(vld1), 32'h1);

        // Two-cycle latency on the registered-output instance
        wr(6'd15, 16'hBEEF);
        re = 1; raddr = 6'd15;
        @(negedge clk);
        re = 0;
        chk("oreg_vld_n1", 32'(vld1), 32'h0);
        @(negedge clk);
        chk("oreg_dout_n2", 32'(dout1), 32'hBEEF);
        chk("oreg_vld_n2", 32'(vld1), 32'h1);
        @(negedge clk);
        chk("oreg_vld_n3", 32'(vld1), 32'h0);

        // Reset in the middle of a second clear sweep
        wr(6'd10, 16'h0077);
        re = 1; raddr = 6'd10;
        @(negedge clk);
        re = 0;
        chk("pre_rst_rd0", 32'(dout0), 32'h77);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_dout0", 32'(dout0), 32'h0);
        rst = 0;
        n0 = 0;
        while (busy0 && n0 < 200) begin
            n0++;
            @(negedge clk);
        end
        chk("reclear_cycles0", 32'(n0), 32'd64);
        re = 1; raddr = 6'd10;
        @(negedge clk);
        re = 0;
        chk("reclear_rd0", 32'(dout0), 32'h0);
        chk("reclear_vld0", 32'(vld0), 32'h1);

        // Randomised traffic with occasional resets, concentrated collisions
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 399) == 0);
            we    = 1'($urandom_range(0, 1));
            re    = 1'($urandom_range(0, 1));
            waddr = 6'($urandom);
            wdata = 16'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom);
            @(negedge clk);
        end
        rst = 0; we = 0; re = 0;
        n0 = 0;
        while (busy0 && n0 < 200) begin
            n0++;
            @(negedge clk);
        end
        chk("final_ready0", 32'(busy0), 32'h0);

`ifdef SDP_RAM_PARITY_EN
        // Flip the stored parity bit of address 7 behind the write port
        wr(6'd7, 16'h005A);
        corrupt = 1;
        dut0.u_core.mem[7] = dut0.u_core.mem[7] ^ 9'h100;
        re = 1; raddr = 6'd7;
        @(negedge clk);
        chk("perr_bad7", 32'(perr0), 32'h1);
        chk("perr_bad7_vld", 32'(vld0), 32'h1);
        raddr = 6'd6;
        @(negedge clk);
        chk("perr_clean6", 32'(perr0), 32'h0);
        re = 0;
        wr(6'd7, 16'h005A);
        corrupt = 0;
        @(negedge clk);
`endif

        mon = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
